bmp_pixel_probe: RTL

- Memory-mapped read-back peripheral on the same CPU bus as the BMP display block.
- The display block writes sprites into the 640x480 6-bit video memory; this block reads them back.
- The CPU programs a rectangle and starts a scan. The block reads each pixel through a dedicated video-memory read port.
- It counts non-background pixels and records the first hit, which gives software collision detection.

---
 rtl/bmp_pkg.sv | 20 ++
 rtl/bmp_probe_addr_gen.sv | 75 +++++++
 rtl/bmp_pixel_probe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bmp_pkg.sv
// bmp_pkg: shared register map, screen geometry and colour defaults for the BMP display/probe blocks.
package bmp_pkg;
    localparam logic [15:0] ADDR_QX   = 16'hC00C;
    localparam logic [15:0] ADDR_QY   = 16'hC00D;
    localparam logic [15:0] ADDR_CTRL = 16'hC00E;
    localparam logic [15:0] ADDR_CNT  = 16'hC00F;
    localparam logic [15:0] ADDR_HITX = 16'hC010;
    localparam logic [15:0] ADDR_HITY = 16'hC011;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam logic [5:0] BG_COLOR_DEF = 6'h00;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_HIT  = 2;
    localparam int ST_CLIP = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} probe_state_t;
endpackage

// File: rtl/bmp_probe_addr_gen.sv
// bmp_probe_addr_gen: walks the probe rectangle in raster order and produces the 640-stride read address.
module bmp_probe_addr_gen
    import bmp_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [9:0]  qx,
    input  logic [8:0]  qy,
    input  logic [5:0]  wm1,
    input  logic [5:0]  hm1,
    output logic [9:0]  px,
    output logic [8:0]  py,
    output logic        clip,
    output logic        last,
    output logic [18:0] raddr
);
    localparam logic [10:0] HX = 11'(H_RES);
    localparam logic [9:0]  VY = 10'(V_RES);

    logic [9:0]  wqx;
    logic [8:0]  wqy;
    logic [5:0]  wm1_q, hm1_q, cx, cy, nx, ny;
    logic [10:0] npx;
    logic [9:0]  npy;
    logic        wrap, adv, nclip;
    logic [18:0] naddr;

    // Registers hold the pixel currently presented on raddr, so data returns one cycle later.
    always_comb begin
        wrap  = cx == wm1_q;
        last  = wrap && cy == hm1_q;
        adv   = load || (step && !last);
        nx    = (load || wrap) ? 6'd0 : cx + 6'd1;
        ny    = load ? 6'd0 : wrap ? cy + 6'd1 : cy;
        npx   = {1'b0, load ? qx : wqx} + {5'b0, nx};
        npy   = {1'b0, load ? qy : wqy} + {4'b0, ny};
        nclip = npx >= HX || npy >= VY;
        naddr = {npy, 9'b0} + {2'b0, npy, 7'b0} + {8'b0, npx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wqx   <= '0;
            wqy   <= '0;
            wm1_q <= '0;
            hm1_q <= '0;
            cx    <= '0;
            cy    <= '0;
            px    <= '0;
            py    <= '0;
            clip  <= 1'b0;
            raddr <= '0;
        end else begin
            if (load) begin
                wqx   <= qx;
                wqy   <= qy;
                wm1_q <= wm1;
                hm1_q <= hm1;
            end
            if (adv) begin
                cx   <= nx;
                cy   <= ny;
                px   <= npx[9:0];
                py   <= npy[8:0];
                clip <= nclip;
                if (!nclip) raddr <= naddr;
            end
        end
    end
endmodule

// File: rtl/bmp_pixel_probe.sv
// bmp_pixel_probe: CPU-programmed rectangle scan of video memory, counting non-background pixels
// and capturing the raster-first hit for software collision detection.
module bmp_pixel_probe
    import bmp_pkg::*;
#(
    parameter logic [5:0] BG_COLOR = BG_COLOR_DEF,
    parameter int         H_RES    = H_RES_DEF,
    parameter int         V_RES    = V_RES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bmp_sel,
    input  logic        mm_we,
    input  logic        mm_re,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [18:0] vm_raddr,
    input  logic [5:0]  vm_rdata
);
    probe_state_t state;
    logic [9:0]  qx, hitx, px, pxd;
    logic [8:0]  qy, hity, py, pyd;
    logic [12:0] cnt;
    logic        busy, done, hit, clipped, clip, last, vld, wr, start;
    logic [15:0] status, rd;
    logic        unused_bits;

    assign wr          = bmp_sel && mm_we;
    assign start       = wr && addr == ADDR_CTRL && wdata[15] && state == IDLE;
    assign unused_bits = ^wdata[14:12];

    bmp_probe_addr_gen #(.H_RES(H_RES), .V_RES(V_RES)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .step  (state == SCAN),
        .qx    (qx),
        .qy    (qy),
        .wm1   (wdata[5:0]),
        .hm1   (wdata[11:6]),
        .px    (px),
        .py    (py),
        .clip  (clip),
        .last  (last),
        .raddr (vm_raddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qx <= '0;
            qy <= '0;
        end else begin
            if (wr && addr == ADDR_QX) qx <= wdata[9:0];
            if (wr && addr == ADDR_QY) qy <= wdata[8:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
            clipped <= 1'b0;
            cnt     <= '0;
            hitx    <= '0;
            hity    <= '0;
            vld     <= 1'b0;
            pxd     <= '0;
            pyd     <= '0;
        end else begin
            vld <= state == SCAN && !clip;
            pxd <= px;
            pyd <= py;
            if (vld && vm_rdata != BG_COLOR) begin
                cnt <= cnt + 13'd1;
                if (!hit) begin
                    hit  <= 1'b1;
                    hitx <= pxd;
                    hity <= pyd;
                end
            end
            case (state)
                IDLE: if (start) begin
                    cnt     <= '0;
                    hit     <= 1'b0;
                    clipped <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b1;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (clip) clipped <= 1'b1;
                    if (last) state <= DRAIN;
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status          = '0;
        status[ST_BUSY] = busy;
        status[ST_DONE] = done;
        status[ST_HIT]  = hit;
        status[ST_CLIP] = clipped;
        rd = addr == ADDR_QX   ? {6'b0, qx}   :
             addr == ADDR_QY   ? {7'b0, qy}   :
             addr == ADDR_CTRL ? status       :
             addr == ADDR_CNT  ? {3'b0, cnt}  :
             addr == ADDR_HITX ? {6'b0, hitx} :
             addr == ADDR_HITY ? {7'b0, hity} : 16'h0;
        rdata = (bmp_sel && mm_re) ? rd : 16'h0;
    end
endmodule
